// File: rtl/alu_pkg.sv
// Shared ALU opcodes, multiply-sequencer state encoding and NZCV bit positions.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_ADDS = 4'b0010;
    localparam logic [3:0] ALU_SUBS = 4'b0011;
    localparam logic [3:0] ALU_CMP  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_XOR  = 4'b1001;
    localparam logic [3:0] ALU_MVN  = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam int unsigned NZCV_N = 3;
    localparam int unsigned NZCV_Z = 2;
    localparam int unsigned NZCV_C = 1;
    localparam int unsigned NZCV_V = 0;

endpackage

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL/MLA controller: shift-add multiply using the shared external ALU as adder.
module mul_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_rm,
    input  logic [WIDTH-1:0] op_rs,
    input  logic [WIDTH-1:0] op_rn,
    input  logic             accumulate,
    input  logic             set_flags,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       nzcv,
    output logic             nzcv_we,
    output logic             busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flg_q, flg_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            flg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            flg_q    <= flg_d;
        end
    end

    // Next-state, datapath update and handshake decode
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        count_d     = count_q;
        flg_d       = flg_q;
        start_ready = 1'b0;
        done_valid  = 1'b0;
        alu_a       = '0;
        alu_b       = '0;

        case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    acc_d    = accumulate ? op_rn : '0;
                    mcand_d  = op_rm;
                    mplier_d = op_rs;
                    flg_d    = set_flags;
                    count_d  = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                alu_a    = acc_q;
                alu_b    = mplier_q[0] ? mcand_q : '0;
                acc_d    = alu_result;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                // Early exit once no set multiplier bits remain above the current one
                if ((count_q == CNT_W'(WIDTH - 1)) ||
                    (EARLY_TERM && ((mplier_q >> 1) == '0))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result and flags are only presented while DONE so they read zero otherwise
    always_comb begin
        result = '0;
        nzcv   = '0;
        if (state_q == DONE) begin
            result         = acc_q;
            nzcv[NZCV_N]   = acc_q[WIDTH-1];
            nzcv[NZCV_Z]   = (acc_q == '0);
        end
    end

    assign nzcv_we     = done_valid & flg_q;
    assign busy        = (state_q != IDLE);
    assign alu_control = ALU_ADD;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer with EARLY_TERM=1 and EARLY_TERM=0 instances.
module tb_mul_sequencer;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   nzcv;
        logic         we;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;
    exp_t q_e[$];
    exp_t q_f[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Early-terminating instance signals
    logic         e_start_valid, e_start_ready, e_accumulate, e_set_flags;
    logic [W-1:0] e_op_rm, e_op_rs, e_op_rn, e_alu_a, e_alu_b, e_alu_result, e_result;
    logic [3:0]   e_alu_control, e_nzcv;
    logic         e_done_valid, e_done_ready, e_nzcv_we, e_busy;

    // Fixed 32-iteration instance signals
    logic         f_start_valid, f_start_ready, f_accumulate, f_set_flags;
    logic [W-1:0] f_op_rm, f_op_rs, f_op_rn, f_alu_a, f_alu_b, f_alu_result, f_result;
    logic [3:0]   f_alu_control, f_nzcv;
    logic         f_done_valid, f_done_ready, f_nzcv_we, f_busy;

    mul_sequencer #(.WIDTH(W), .EARLY_TERM(1'b1)) u_dut_e (
        .clk(clk), .rst_n(rst_n),
        .start_valid(e_start_valid), .start_ready(e_start_ready),
        .op_rm(e_op_rm), .op_rs(e_op_rs), .op_rn(e_op_rn),
        .accumulate(e_accumulate), .set_flags(e_set_flags),
        .alu_a(e_alu_a), .alu_b(e_alu_b), .alu_control(e_alu_control),
        .alu_result(e_alu_result),
        .done_valid(e_done_valid), .done_ready(e_done_ready),
        .result(e_result), .nzcv(e_nzcv), .nzcv_we(e_nzcv_we), .busy(e_busy)
    );

    mul_sequencer #(.WIDTH(W), .EARLY_TERM(1'b0)) u_dut_f (
        .clk(clk), .rst_n(rst_n),
        .start_valid(f_start_valid), .start_ready(f_start_ready),
        .op_rm(f_op_rm), .op_rs(f_op_rs), .op_rn(f_op_rn),
        .accumulate(f_accumulate), .set_flags(f_set_flags),
        .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_control(f_alu_control),
        .alu_result(f_alu_result),
        .done_valid(f_done_valid), .done_ready(f_done_ready),
        .result(f_result), .nzcv(f_nzcv), .nzcv_we(f_nzcv_we), .busy(f_busy)
    );

    // Behavioural ALU for each instance
    always_comb begin
        case (e_alu_control)
            ALU_ADD: e_alu_result = e_alu_a + e_alu_b;
            ALU_SUB: e_alu_result = e_alu_a - e_alu_b;
            default: e_alu_result = e_alu_a ^ e_alu_b;
        endcase
    end

    always_comb begin
        case (f_alu_control)
            ALU_ADD: f_alu_result = f_alu_a + f_alu_b;
            ALU_SUB: f_alu_result = f_alu_a - f_alu_b;
            default: f_alu_result = f_alu_a ^ f_alu_b;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Result monitors: pop an expectation on each done transfer
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && e_done_valid && e_done_ready) begin
            if (q_e.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL e_unexpected_done: got result %0h with empty queue", e_result);
            end else begin
                x = q_e.pop_front();
                chk("e_result", 64'(e_result), 64'(x.res));
                chk("e_nzcv", 64'(e_nzcv), 64'(x.nzcv));
                chk("e_nzcv_we", 64'(e_nzcv_we), 64'(x.we));
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && f_done_valid && f_done_ready) begin
            if (q_f.size() == 0) begin
                vecs++;
                errs++;
                $display("FAIL f_unexpected_done: got result %0h with empty queue", f_result);
            end else begin
                x = q_f.pop_front();
                chk("f_result", 64'(f_result), 64'(x.res));
                chk("f_nzcv", 64'(f_nzcv), 64'(x.nzcv));
                chk("f_nzcv_we", 64'(f_nzcv_we), 64'(x.we));
            end
        end
    end

    task automatic drive_start(input bit sel, input logic [W-1:0] rm, input logic [W-1:0] rs,
                               input logic [W-1:0] rn, input logic acc, input logic sf);
        if (sel) begin
            f_op_rm = rm; f_op_rs = rs; f_op_rn = rn;
            f_accumulate = acc; f_set_flags = sf; f_start_valid = 1'b1;
        end else begin
            e_op_rm = rm; e_op_rs = rs; e_op_rn = rn;
            e_accumulate = acc; e_set_flags = sf; e_start_valid = 1'b1;
        end
    endtask

    // Issue one op, check first RUN-cycle ALU operands and done_valid latency
    task automatic run_op(input bit sel, input logic [W-1:0] rm, input logic [W-1:0] rs,
                          input logic [W-1:0] rn, input logic acc, input logic sf,
                          input int exp_lat, input string tag);
        int  t;
        int  lat;
        bit  seen;
        @(posedge clk); #1;
        drive_start(sel, rm, rs, rn, acc, sf);
        chk({tag, "_start_ready"}, 64'(sel ? f_start_ready : e_start_ready), 64'(1));
        @(posedge clk); #1;
        t = cyc;
        if (sel) f_start_valid = 1'b0; else e_start_valid = 1'b0;
        chk({tag, "_busy"}, 64'(sel ? f_busy : e_busy), 64'(1));
        chk({tag, "_alu_a0"}, 64'(sel ? f_alu_a : e_alu_a), 64'(acc ? rn : '0));
        chk({tag, "_alu_b0"}, 64'(sel ? f_alu_b : e_alu_b), 64'(rs[0] ? rm : '0));
        chk({tag, "_alu_ctl"}, 64'(sel ? f_alu_control : e_alu_control), 64'(ALU_ADD));
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < 80 && !seen; k++) begin
            @(negedge clk);
            if (sel ? f_done_valid : e_done_valid) begin
                seen = 1'b1;
                lat  = cyc + 1 - t;
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    // Wait for the done transfer edge and confirm return to IDLE
    task automatic finish_op(input bit sel, input string tag);
        @(posedge clk); #1;
        chk({tag, "_ready_back"}, 64'(sel ? f_start_ready : e_start_ready), 64'(1));
        chk({tag, "_idle"}, 64'(sel ? f_busy : e_busy), 64'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_start_ready"}, 64'(e_start_ready), 64'(1));
        chk({tag, "_busy"}, 64'(e_busy), 64'(0));
        chk({tag, "_done_valid"}, 64'(e_done_valid), 64'(0));
        chk({tag, "_nzcv_we"}, 64'(e_nzcv_we), 64'(0));
        chk({tag, "_result"}, 64'(e_result), 64'(0));
        chk({tag, "_nzcv"}, 64'(e_nzcv), 64'(0));
        chk({tag, "_alu_a"}, 64'(e_alu_a), 64'(0));
        chk({tag, "_alu_b"}, 64'(e_alu_b), 64'(0));
        chk({tag, "_alu_ctl"}, 64'(e_alu_control), 64'(0));
    endtask

    initial begin
        e_start_valid = 1'b0; e_op_rm = '0; e_op_rs = '0; e_op_rn = '0;
        e_accumulate = 1'b0; e_set_flags = 1'b0; e_done_ready = 1'b1;
        f_start_valid = 1'b0; f_op_rm = '0; f_op_rs = '0; f_op_rn = '0;
        f_accumulate = 1'b0; f_set_flags = 1'b0; f_done_ready = 1'b1;

        #1;
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // MUL 3*5 with flags
        q_e.push_back('{res: 32'd15, nzcv: 4'b0000, we: 1'b1});
        run_op(1'b0, 32'd3, 32'd5, 32'd0, 1'b0, 1'b1, 4, "mul3x5");
        finish_op(1'b0, "mul3x5");

        // MLA 0xFFFFFFFF*2 + 1 wraps to 0xFFFFFFFF
        q_e.push_back('{res: 32'hFFFF_FFFF, nzcv: 4'b1000, we: 1'b1});
        run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b1, 1'b1, 3, "mla_wrap");
        finish_op(1'b0, "mla_wrap");

        // Zero multiplier: single RUN cycle, Z set, no flag write
        q_e.push_back('{res: 32'd0, nzcv: 4'b0100, we: 1'b0});
        run_op(1'b0, 32'h1234, 32'd0, 32'd0, 1'b0, 1'b0, 2, "rs_zero");
        finish_op(1'b0, "rs_zero");

        // MSB multiplier with consumer stalled; start attempts during DONE must be ignored
        e_done_ready = 1'b0;
        q_e.push_back('{res: 32'h8000_0000, nzcv: 4'b1000, we: 1'b1});
        run_op(1'b0, 32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 33, "hold");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            drive_start(1'b0, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
            chk("hold_done_valid", 64'(e_done_valid), 64'(1));
            chk("hold_result", 64'(e_result), 64'(32'h8000_0000));
            chk("hold_nzcv", 64'(e_nzcv), 64'(4'b1000));
            chk("hold_start_ready", 64'(e_start_ready), 64'(0));
        end
        e_start_valid = 1'b0;
        e_done_ready  = 1'b1;
        finish_op(1'b0, "hold");

        // Asynchronous reset in the middle of a long RUN
        @(posedge clk); #1;
        drive_start(1'b0, 32'd5, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        e_start_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_rst");
        @(negedge clk);
        rst_n = 1'b1;
        q_e.push_back('{res: 32'd42, nzcv: 4'b0000, we: 1'b0});
        run_op(1'b0, 32'd7, 32'd6, 32'd0, 1'b0, 1'b0, 4, "mul7x6");
        finish_op(1'b0, "mul7x6");

        // Fixed-iteration instance always takes 32 RUN cycles
        q_f.push_back('{res: 32'd9, nzcv: 4'b0000, we: 1'b0});
        run_op(1'b1, 32'd9, 32'd1, 32'd0, 1'b0, 1'b0, 33, "full_mul9");
        finish_op(1'b1, "full_mul9");

        q_f.push_back('{res: 32'd16, nzcv: 4'b0000, we: 1'b1});
        run_op(1'b1, 32'd2, 32'd3, 32'd10, 1'b1, 1'b1, 33, "full_mla");
        finish_op(1'b1, "full_mla");

        repeat (3) @(posedge clk);
        #1;
        chk("e_queue_drained", 64'(q_e.size()), 64'(0));
        chk("f_queue_drained", 64'(q_f.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle MUL/MLA controller for the ARM7TDMI execute stage. It uses the shared combinational ALU as its adder, issuing the ADD opcode once per cycle under a shift-add algorithm. It accepts one multiply over a valid/ready handshake and returns the low 32 bits of the product, plus the sum with Rn for MLA. It also returns NZCV and a flag-update strobe for the CPSR.

## Interface
- WIDTH, 32, operand/result width
- EARLY_TERM, 1, 1 = stop when remaining multiplier bits are all zero; 0 = always 32 iterations
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start_valid  in  1  request valid
- start_ready  out  1  sequencer can accept
- op_rm  in  WIDTH  multiplicand
- op_rs  in  WIDTH  multiplier
- op_rn  in  WIDTH  accumulate operand
- accumulate  in  1  1 = MLA, 0 = MUL
- set_flags  in  1  S bit
- alu_a  out  WIDTH  ALU operand_a
- alu_b  out  WIDTH  ALU operand_b
- alu_control  out  4  ALU opcode, always ADD (4'b0000)
- alu_result  in  WIDTH  ALU result
- done_valid  out  1  result valid
- done_ready  in  1  consumer accepts result
- result  out  WIDTH  product (plus Rn for MLA), mod 2^WIDTH
- nzcv  out  4  {N,Z,C,V}
- nzcv_we  out  1  flag write strobe, = done_valid & captured set_flags
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid: acc<=accumulate?op_rn:0; mcand<=op_rm; mplier<=op_rs; flg<=set_flags; count<=0; go to RUN.
- RUN, every cycle:
  - alu_a=acc; alu_b=mplier[0]?mcand:0; acc<=alu_result.
  - mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
- Exit RUN to DONE after the cycle where either:
  - count==WIDTH-1, or
  - EARLY_TERM=1 and (mplier>>1)==0.
- DONE:
  - done_valid=1; result=acc.
  - nzcv={acc[WIDTH-1], acc==0, 1'b0, 1'b0}.
  - C and V are defined as 0.
  - On done_ready go to IDLE.
- Outside RUN, alu_a=alu_b=0.
- Arithmetic: only the low WIDTH bits are kept, so signed and unsigned results are identical. No carry-out is used. The ALU nzcv output is ignored.
- Boundary behaviour:
  - op_rs==0: exactly one RUN cycle (no add), result = acc init.
  - op_rs MSB set: full 32 RUN cycles.
  - start_valid in RUN or DONE is ignored, since start_ready=0. There is no same-cycle restart from DONE.
  - done_ready held low: DONE holds result and nzcv stable indefinitely.
  - rst_n low at any point, including mid-RUN: immediately IDLE, all registers zero, and all outputs at reset values.

## Timing
- Reset values:
  - start_ready=1.
  - busy, done_valid, nzcv_we = 0.
  - result, nzcv, alu_a, alu_b = 0.
  - alu_control=4'b0000.
- Latency:
  - Accept at edge T; RUN cycles T+1..T+N; done_valid visible from T+N+1.
  - N = WIDTH with EARLY_TERM=0.
  - Otherwise N = max(1, index of highest set bit of op_rs + 1).
- Handshakes:
  - Start transfer on start_valid&start_ready.
  - Done transfer on done_valid&done_ready; start_ready returns the next cycle.
- Throughput: one operation per N+2 cycles with done_ready tied high.
- Combinational path: the ALU path acc→alu_a→alu_result→acc is one cycle.

## Structure
- Shared package alu_pkg holds:
  - ALU opcode constants: ADD 4'b0000, SUB 4'b0001, ADDS 4'b0010, SUBS 4'b0011, CMP 4'b0100, AND 4'b0111, OR 4'b1000, XOR 4'b1001, MVN 4'b1010.
  - The sequencer state enum {IDLE, RUN, DONE}.
  - NZCV bit-index constants.
- No sub-module. The ALU is instantiated by the parent and wired through the alu_* ports, so a top-level mux can share it.
- Bench instantiates mul_sequencer plus the ALU.

## Test plan
- MUL rm=3, rs=5, set_flags=1, EARLY_TERM=1 → result 15, 3 RUN cycles, done_valid at T+4, nzcv=0000, nzcv_we=1.
- MLA rm=0xFFFFFFFF, rs=2, rn=1 → result 0xFFFFFFFF, nzcv=1000.
- MUL rs=0, rm=0x1234 → result 0, nzcv=0100, 1 RUN cycle, done_valid at T+2.
- MUL rm=1, rs=0x80000000 with done_ready low 5 cycles → result 0x80000000 after 32 RUN cycles, held stable; start_valid during DONE ignored.
- rst_n pulsed low mid-RUN → all outputs reset values asynchronously; after release, MUL 7×6 returns 42.
- EARLY_TERM=0, rs=1, rm=9 → result 9, done_valid exactly at T+33.
